// File: rtl/mult_arbiter_if.sv
// Bundle between the requesters, the shared multiplier and the arbiter.
// A request is consumed in a cycle where req_valid[i] && req_ready[i]; responses have no backpressure.
interface mult_arbiter_if #(
  parameter int D_W   = 8,
  parameter int N_REQ = 2
);
  logic                   hold;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*D_W-1:0]   req_a;
  logic [N_REQ*D_W-1:0]   req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [D_W-1:0]         mul_a;
  logic [D_W-1:0]         mul_b;
  logic [2*D_W-1:0]       mul_out;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*D_W-1:0]       rsp_data;
  logic                   busy;
  logic [15:0]            issue_cnt;

  modport slave (
    input  hold, req_valid, req_a, req_b, mul_out,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy, issue_cnt
  );

  modport master (
    output hold, req_valid, req_a, req_b, mul_out,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, busy, issue_cnt
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiplier between N_REQ requesters.
// A tag pipeline of depth LAT routes each product back to the requester that issued it.
module mult_arbiter #(
  parameter int D_W   = 8,
  parameter int N_REQ = 2,
  parameter int LAT   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mult_arbiter_if.slave              bus,
  output logic [$clog2(N_REQ)-1:0]   dbg_ptr
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0] N_LAST = (IDX_W+1)'(N_REQ - 1);
  localparam logic [IDX_W:0] N_FULL = (IDX_W+1)'(N_REQ);

  logic [IDX_W-1:0] r_ptr;
  logic [LAT-1:0]   r_tag_vld;
  logic [IDX_W-1:0] r_tag_idx [LAT];
  logic [15:0]      r_issue_cnt;

  logic             w_gnt_vld;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W:0]   w_cand;

  // Search upward from r_ptr with wrap; the extra bit in w_cand absorbs the overflow.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_ptr;
    w_cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand > N_LAST) w_cand = w_cand - N_FULL;
      if (!w_gnt_vld && bus.req_valid[w_cand[IDX_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[IDX_W-1:0];
      end
    end
    if (!rst_n || bus.hold) w_gnt_vld = 1'b0;
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
    if (w_gnt_vld) begin
      bus.req_ready[w_gnt_idx] = 1'b1;
      bus.mul_a = bus.req_a[int'(w_gnt_idx)*D_W +: D_W];
      bus.mul_b = bus.req_b[int'(w_gnt_idx)*D_W +: D_W];
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    if (r_tag_vld[LAT-1]) begin
      bus.rsp_valid[r_tag_idx[LAT-1]] = 1'b1;
      bus.rsp_data = bus.mul_out;
    end
  end

  assign bus.busy      = |r_tag_vld;
  assign bus.issue_cnt = r_issue_cnt;
  assign dbg_ptr       = r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_tag_vld   <= '0;
      r_issue_cnt <= '0;
      for (int k = 0; k < LAT; k++) r_tag_idx[k] <= '0;
    end else begin
      r_tag_vld[0] <= w_gnt_vld;
      r_tag_idx[0] <= w_gnt_idx;
      for (int k = 1; k < LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
      if (w_gnt_vld) begin
        r_issue_cnt <= r_issue_cnt + 16'd1;
        r_ptr       <= ({1'b0, w_gnt_idx} == N_LAST) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter D_W, default 8, giving the operand width in bits.
REQ-002 SHALL have parameter N_REQ, default 2, giving the number of requesters (N_REQ >= 2).
REQ-003 SHALL have parameter LAT, default 3, giving the fixed multiplier latency in cycles (LAT >= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port hold  input  1  when 1, no new grants are made; in-flight operations drain.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-008 SHALL have port req_a  input  N_REQ*D_W  operand a; requester i occupies bits [i*D_W +: D_W].
REQ-009 SHALL have port req_b  input  N_REQ*D_W  operand b, packed as req_a.
REQ-010 SHALL have port req_ready  output  N_REQ  one-hot grant; the request is consumed in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-011 SHALL have port mul_a  output  D_W  operand a to the shared multiplier.
REQ-012 SHALL have port mul_b  output  D_W  operand b to the shared multiplier.
REQ-013 SHALL have port mul_out  input  2*D_W  product from the multiplier, LAT cycles after its operands were presented.
REQ-014 SHALL have port rsp_valid  output  N_REQ  one-hot, indicating a result for requester i; it has no backpressure.
REQ-015 SHALL have port rsp_data  output  2*D_W  result, equal to mul_out whenever rsp_valid is nonzero.
REQ-016 SHALL have port busy  output  1  1 while any operation is in flight.
REQ-017 SHALL have port issue_cnt  output  16  free-running count of issued operations, wrapping at 2^16.

Function
REQ-018 SHALL grant at most one requester per cycle, and only when hold=0 and that requester's req_valid=1.
REQ-019 SHALL select the grant by round-robin: the first requester with req_valid=1 searching from pointer ptr upward, modulo N_REQ.
REQ-020 SHALL set ptr to (g+1) mod N_REQ on each grant to g, and leave ptr unchanged in cycles with no grant.
REQ-021 SHALL derive req_ready combinationally from the current req_valid, ptr and hold.
REQ-022 SHALL drive mul_a and mul_b combinationally with the granted requester's operands, and with 0 when there is no grant.
REQ-023 SHALL track each grant in a tag pipeline of depth LAT, where each entry holds a valid bit and the requester index.
REQ-024 SHALL, for a grant to requester i in cycle t, assert rsp_valid[i]=1 in cycle t+LAT only, with rsp_data=mul_out.
REQ-025 SHALL drive rsp_data=0 and rsp_valid=0 in cycles with no completing entry.
REQ-026 SHALL deliver results in issue order; back-to-back grants produce back-to-back responses.
REQ-027 SHALL hold busy=1 whenever any tag pipeline entry is valid; a grant made this cycle does not affect busy until the next cycle.
REQ-028 SHALL increment issue_cnt by 1 per grant, with 0xFFFF wrapping to 0x0000.
REQ-029 SHALL, on hold rising mid-stream, keep all in-flight tags and still deliver their responses; busy falls LAT cycles after the last grant.
REQ-030 SHALL treat requester operands as unsigned; the product width is 2*D_W with no truncation.

Reset
REQ-031 SHALL, while rst_n=0, immediately clear ptr to 0, clear all tag entries to invalid, and clear issue_cnt to 0.
REQ-032 SHALL drive req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_data=0 and busy=0 while rst_n=0.
REQ-033 SHALL discard operations in flight when reset is asserted mid-operation, producing no response for them after reset is released.

Verification
REQ-034 SHALL be verified by: requester 0 only, req_a=3, req_b=5 in cycle 0 -> rsp_valid=01 with rsp_data=15 in cycle 3, and issue_cnt=1.
REQ-035 SHALL be verified by: both requesters continuously valid for 6 cycles from reset -> grants 0,1,0,1,0,1, each with its rsp_valid LAT cycles later, and issue_cnt=6.
REQ-036 SHALL be verified by: N_REQ=4, valid only on requesters 1 and 3 with ptr=2 -> grant 3 then 1, with ptr wrapping to 0 and then to 2.
REQ-037 SHALL be verified by: hold=1 asserted the cycle after grants at cycles 0 and 1 -> responses at cycles 3 and 4, no further grants, busy=0 from cycle 5.
REQ-038 SHALL be verified by: rst_n pulsed low in cycle 2 after grants at cycles 0 and 1 -> no rsp_valid in cycles 3 and 4, with ptr=0 and issue_cnt=0.
REQ-039 SHALL be verified by: a checker comparing every rsp_data against req_a*req_b for the matching requester over 10k random cycles -> zero mismatches.
